// File: rtl/quant_pkg.sv
// Shared fixed-point constants and the round/saturate helper for the quantizer write-back path.
package quant_pkg;

  localparam int QBITS  = 8;
  localparam int DWIDTH = 16;
  localparam int QWIDTH = 8;
  localparam int PWIDTH = 2 * DWIDTH + 1;
  localparam int QMAX   = 2 ** (QWIDTH - 1) - 1;
  localparam int QMIN   = -(2 ** (QWIDTH - 1));

  // Returns {sat, q}: add half an LSB, arithmetic shift (floor), then clip to the code range.
  function automatic logic [QWIDTH:0] sat_round(input logic signed [PWIDTH-1:0] p);
    logic signed [PWIDTH:0]       t;
    logic signed [PWIDTH-QBITS:0] r;
    t = {p[PWIDTH-1], p} + (PWIDTH + 1)'(2 ** (QBITS - 1));
    r = (PWIDTH - QBITS + 1)'(t >>> QBITS);
    if (r > QMAX)
      sat_round = {1'b1, QWIDTH'(QMAX)};
    else if (r < QMIN)
      sat_round = {1'b1, QWIDTH'(QMIN)};
    else
      sat_round = {1'b0, r[QWIDTH-1:0]};
  endfunction

endpackage

// File: rtl/quant.sv
// Quantizer: q = sat(round(((x - offset) * inv_scale) >>> QBITS)), 3-stage pipeline with global stall.
module quant
  import quant_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int QWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DWIDTH-1:0] w_inv_scale,
  input  logic [DWIDTH-1:0] w_offset,
  input  logic [DWIDTH-1:0] b_inv_scale,
  input  logic [DWIDTH-1:0] b_offset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              which,
  input  logic [DWIDTH-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [QWIDTH-1:0] q,
  output logic              out_which,
  input  logic              clr_stat,
  output logic [CWIDTH-1:0] sat_count,
  output logic              busy
);

  localparam int PW = 2 * DWIDTH + 1;

  logic [DWIDTH-1:0] inv_r [2];
  logic [DWIDTH-1:0] off_r [2];

  logic              s1_valid, s2_valid, s3_valid;
  logic              s1_which, s2_which, s3_which;
  logic [DWIDTH:0]   s1_d;
  logic [DWIDTH-1:0] s1_scale;
  logic [PW-1:0]     s2_p;
  logic [QWIDTH-1:0] s3_q;
  logic              s3_sat;

  logic              adv;
  logic [DWIDTH-1:0] inv_sel, off_sel;
  logic [PW-1:0]     d_ext, scale_ext;
  logic [quant_pkg::QWIDTH:0] sr;

  always_comb begin
    adv       = !s3_valid || out_ready;
    inv_sel   = inv_r[which];
    off_sel   = off_r[which];
    d_ext     = {{DWIDTH{s1_d[DWIDTH]}}, s1_d};
    scale_ext = {{(DWIDTH + 1){s1_scale[DWIDTH-1]}}, s1_scale};
    sr        = sat_round(quant_pkg::PWIDTH'(s2_p));
  end

  assign in_ready  = adv;
  assign out_valid = s3_valid;
  assign q         = s3_q;
  assign out_which = s3_which;
  assign busy      = s1_valid || s2_valid || s3_valid;

  // Slots update at the edge, so an element accepted alongside load still sees the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_r[0] <= '0;
      inv_r[1] <= '0;
      off_r[0] <= '0;
      off_r[1] <= '0;
    end else if (load) begin
      inv_r[0] <= w_inv_scale;
      off_r[0] <= w_offset;
      inv_r[1] <= b_inv_scale;
      off_r[1] <= b_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_which <= 1'b0;
      s1_d     <= '0;
      s1_scale <= '0;
      s2_valid <= 1'b0;
      s2_which <= 1'b0;
      s2_p     <= '0;
      s3_valid <= 1'b0;
      s3_which <= 1'b0;
      s3_q     <= '0;
      s3_sat   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_which <= which;
      s1_d     <= {x[DWIDTH-1], x} - {off_sel[DWIDTH-1], off_sel};
      s1_scale <= inv_sel;
      s2_valid <= s1_valid;
      s2_which <= s1_which;
      // Both operands sign-extended to full product width, so the truncated product is the signed one.
      s2_p     <= d_ext * scale_ext;
      s3_valid <= s2_valid;
      s3_which <= s2_which;
      s3_q     <= sr[QWIDTH-1:0];
      s3_sat   <= sr[quant_pkg::QWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stat)
      sat_count <= '0;
    else if (s3_valid && out_ready && s3_sat && (sat_count != '1))
      sat_count <= sat_count + 1'b1;
  end

endmodule

// File: tb/tb_quant.sv
// Directed-vector bench for quant: table of single elements plus stall, load, reset and round-trip sequences.
module tb_quant;

  logic        clk = 1'b0;
  logic        rst, load, in_valid, in_ready, which, out_valid, out_ready, out_which, clr_stat, busy;
  logic [15:0] w_inv, w_off, b_inv, b_off, x, sat_count;
  logic [7:0]  q;

  int checks   = 0;
  int failures = 0;

  quant #(.DWIDTH(16), .QWIDTH(8), .CWIDTH(16)) dut (
    .clk(clk), .rst(rst), .load(load),
    .w_inv_scale(w_inv), .w_offset(w_off), .b_inv_scale(b_inv), .b_offset(b_off),
    .in_valid(in_valid), .in_ready(in_ready), .which(which), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .out_which(out_which),
    .clr_stat(clr_stat), .sat_count(sat_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   ph;
    logic wh;
    int   xv;
    int   qe;
    int   se;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_params(input int wi, input int wo, input int bi, input int bo);
    w_inv = 16'(wi); w_off = 16'(wo); b_inv = 16'(bi); b_off = 16'(bo);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic send(input logic wh, input int xv);
    in_valid = 1'b1; which = wh; x = 16'(xv);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, output int qv, output logic ow);
    int n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s: got no out_valid expected out_valid within 10 cycles", name);
    end
    qv = int'($signed(q));
    ow = out_which;
  endtask

  initial begin
    int   qv, exp_sat, sent, got, xv, xr, err;
    logic ow;
    logic acc, tk;

    rst = 1'b1; load = 1'b0; in_valid = 1'b0; which = 1'b0; x = '0;
    out_ready = 1'b1; clr_stat = 1'b0;
    w_inv = '0; w_off = '0; b_inv = '0; b_off = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // Latency: valid appears after the third edge counting the accepting one.
    set_params(256, 0, 512, 10);
    in_valid = 1'b1; which = 1'b0; x = 16'd100;
    tick();
    in_valid = 1'b0;
    chk("lat_e1_valid", out_valid, 0);
    tick();
    chk("lat_e2_valid", out_valid, 0);
    tick();
    chk("lat_e3_valid", out_valid, 1);
    chk("lat_q", $signed(q), 100);
    tick();
    chk("lat_sat_count", sat_count, 0);

    tv[0]  = '{0, 1'b0,   100,  100, 0};
    tv[1]  = '{0, 1'b0,  1000,  127, 1};
    tv[2]  = '{0, 1'b0, -1000, -128, 1};
    tv[3]  = '{0, 1'b1,    20,   20, 0};
    tv[4]  = '{0, 1'b0,   127,  127, 0};
    tv[5]  = '{0, 1'b0,   128,  127, 1};
    tv[6]  = '{0, 1'b0,  -128, -128, 0};
    tv[7]  = '{0, 1'b1,    -5,  -30, 0};
    tv[8]  = '{1, 1'b0,     3,    2, 0};
    tv[9]  = '{1, 1'b0,    -3,   -1, 0};
    tv[10] = '{1, 1'b0,     1,    1, 0};
    tv[11] = '{1, 1'b0,    -1,    0, 0};
    tv[12] = '{1, 1'b1,  5000,    0, 0};
    tv[13] = '{1, 1'b1, -7000,    0, 0};

    exp_sat = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 8) begin
        chk("sat_count_ph0", sat_count, exp_sat);
        set_params(128, 0, 0, 0);
      end
      send(tv[i].wh, tv[i].xv);
      wait_out($sformatf("vec%0d", i), qv, ow);
      chk($sformatf("vec%0d_q", i), qv, tv[i].qe);
      chk($sformatf("vec%0d_which", i), ow, tv[i].wh);
      exp_sat += tv[i].se;
      tick();
    end
    chk("sat_count_ph1", sat_count, exp_sat);

    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("clr_stat", sat_count, 0);

    // Clear coincident with a saturated consume must leave zero.
    set_params(256, 0, 512, 10);
    send(1'b0, 1000);
    wait_out("coinc", qv, ow);
    chk("coinc_q", qv, 127);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("coinc_clear", sat_count, 0);

    // Backpressure: 8 elements, consumer stalled for the first 6 cycles.
    sent = 0; got = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c >= 6);
      in_valid  = (sent < 8);
      which     = 1'b0;
      x         = 16'(10 + sent);
      #1;
      acc = in_valid && in_ready;
      tk  = out_valid && out_ready;
      if (c == 3) chk("bp_in_ready_held", in_ready, 0);
      if (c >= 3 && c <= 5) begin
        chk("bp_stall_valid", out_valid, 1);
        chk("bp_stall_q", $signed(q), 10);
      end
      if (tk) begin
        chk("bp_order", $signed(q), 10 + got);
        got++;
      end
      if (acc) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", got, 8);
    chk("bp_busy", busy, 0);

    // Load coincident with acceptance: first element sees the old scale.
    in_valid = 1'b1; which = 1'b0; x = 16'd50;
    w_inv = 16'd512; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out("ldb0", qv, ow);
    chk("ldb0_q", qv, 50);
    tick();
    wait_out("ldb1", qv, ow);
    chk("ldb1_q", qv, 100);
    tick();

    // Reset mid-stream with three elements in flight.
    set_params(256, 0, 512, 10);
    send(1'b0, 2000);
    wait_out("presat", qv, ow);
    tick();
    chk("presat_count", sat_count, 1);
    in_valid = 1'b1; which = 1'b0; x = 16'd5;
    tick(); tick(); tick();
    in_valid = 1'b0;
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sat_count", sat_count, 0);
    tick(); tick();
    chk("mid_no_ghost", out_valid, 0);
    send(1'b0, 100);
    wait_out("mid_slot0", qv, ow);
    chk("mid_slot0_q", qv, 0);
    tick();
    send(1'b1, 100);
    wait_out("mid_slot1", qv, ow);
    chk("mid_slot1_q", qv, 0);
    tick();

    // Round trip against a dequantizer with step 4.0 and offset 30.
    set_params(64, 30, 0, 0);
    for (int i = 0; i < 8; i++) begin
      xv = int'($urandom_range(1000, 0)) - 500 + 30;
      send(1'b0, xv);
      wait_out("rt", qv, ow);
      xr  = qv * 4 + 30;
      err = (xv > xr) ? xv - xr : xr - xv;
      chk($sformatf("rt_err_x%0d", xv), (err <= 4) ? 1 : 0, 1);
      tick();
    end
    chk("rt_sat_count", sat_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
